alu_bf16_arbiter: RTL and testbench

- Shares one alu_bf16 instance between NUM_REQ independent requesters.
- Each requester has a valid/ready request port and a response port.
- Arbitration is round-robin with one issue per clock. The block is fully pipelined, with no bubbles between back-to-back issues.
- A shadow pipeline tracks the requester ID and opcode of every in-flight operation. It drives alu_ctrl at the retire cycle, because the ALU output select is combinational on alu_ctrl, and it routes the result back to the originating requester.

---
 rtl/alu_bf16_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_bf16_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bf16_arbiter.sv
// Round-robin sharing of one bf16 ALU between NUM_REQ requesters; one issue per clock, no bubbles.
// Response latency ALU_LATENCY+1 edges after acceptance; no response backpressure, grants gated by issue_en.
module alu_bf16_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1,
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int CW         = $clog2(ALU_LATENCY + 2)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_en,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_op,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [15:0]           resp_data,
    output logic                  resp_err,
    output logic [15:0]           alu_a,
    output logic [15:0]           alu_b,
    output logic [3:0]            alu_ctrl,
    input  logic [15:0]           alu_y,
    output logic [CW-1:0]         inflight
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;

    logic [IDW-1:0]     last_grant_q;
    logic [15:0]        alu_a_q, alu_b_q;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [15:0]        resp_data_q, resp_data_d;
    logic               resp_err_q;
    logic [CW-1:0]      inflight_q, inflight_d;

    // Shadow pipeline: stage ALU_LATENCY is the op whose result is on alu_y now.
    logic               sh_vld_q [ALU_LATENCY+1];
    logic [IDW-1:0]     sh_id_q  [ALU_LATENCY+1];
    logic [3:0]         sh_op_q  [ALU_LATENCY+1];

    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic [IDW-1:0]     acc_id;
    logic [3:0]         acc_op;
    logic [15:0]        acc_a, acc_b;
    logic               ret_vld, ret_ok;
    logic [3:0]         ret_op;

    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && issue_en && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign req_ready = grant & {NUM_REQ{reset_n}};
    assign accept    = |req_ready;

    always_comb begin
        acc_id = '0;
        acc_op = '0;
        acc_a  = '0;
        acc_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                acc_id = IDW'(i);
                acc_op = req_op[i*4 +: 4];
                acc_a  = req_a[i*16 +: 16];
                acc_b  = req_b[i*16 +: 16];
            end
        end
    end

    assign ret_vld = sh_vld_q[ALU_LATENCY];
    assign ret_op  = sh_op_q[ALU_LATENCY];
    assign ret_ok  = ret_vld && (ret_op == OP_ADD || ret_op == OP_MUL);

    always_comb begin
        alu_ctrl     = ret_ok ? ret_op : 4'b0000;
        resp_valid_d = ret_vld ? (NUM_REQ'(1) << sh_id_q[ALU_LATENCY]) : '0;
        resp_data_d  = ret_ok ? alu_y : 16'h0000;
        inflight_d   = inflight_q + {{(CW-1){1'b0}}, accept} - {{(CW-1){1'b0}}, ret_vld};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= ALU_LATENCY; k++) begin
                sh_vld_q[k] <= 1'b0;
                sh_id_q[k]  <= '0;
                sh_op_q[k]  <= '0;
            end
            last_grant_q <= IDW'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            inflight_q   <= '0;
        end else begin
            sh_vld_q[0] <= accept;
            sh_id_q[0]  <= acc_id;
            sh_op_q[0]  <= acc_op;
            for (int k = 1; k <= ALU_LATENCY; k++) begin
                sh_vld_q[k] <= sh_vld_q[k-1];
                sh_id_q[k]  <= sh_id_q[k-1];
                sh_op_q[k]  <= sh_op_q[k-1];
            end
            if (accept) begin
                alu_a_q      <= acc_a;
                alu_b_q      <= acc_b;
                last_grant_q <= acc_id;
            end
            resp_valid_q <= resp_valid_d;
            if (ret_vld) begin
                resp_data_q <= resp_data_d;
                resp_err_q  <= !ret_ok;
            end
            inflight_q <= inflight_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_alu_bf16_arbiter.sv
// Bench for alu_bf16_arbiter: behavioural ALU, round-robin reference and in-order response scoreboard.
module tb_alu_bf16_arbiter;
    localparam int N  = 4;
    localparam int L  = 1;
    localparam int CW = $clog2(L + 2);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              issue_en = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [4*N-1:0]    req_op = '0;
    logic [16*N-1:0]   req_a = '0;
    logic [16*N-1:0]   req_b = '0;
    logic [N-1:0]      resp_valid;
    logic [15:0]       resp_data;
    logic              resp_err;
    logic [15:0]       alu_a, alu_b, alu_y;
    logic [3:0]        alu_ctrl;
    logic [CW-1:0]     inflight;

    alu_bf16_arbiter #(.NUM_REQ(N), .ALU_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err), .alu_a(alu_a),
        .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y), .inflight(inflight)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // bf16 arithmetic via doubles; operands are kept in a normal, non-overflowing range.
    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] d;
        if (h[14:7] == 8'd0) return 0.0;
        d = {h[15], {3'b000, h[14:7]} + 11'd896, h[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] t;
        if (r == 0.0) return 16'h0000;
        d = $realtobits(r);
        t = d[62:52] - 11'd896;
        return {d[63], t[7:0], d[51:45]};
    endfunction

    function automatic logic [16:0] exp_of(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'b0001: return {1'b0, r2bf(bf2r(a) + bf2r(b))};
            4'b0010: return {1'b0, r2bf(bf2r(a) * bf2r(b))};
            default: return {1'b1, 16'h0000};
        endcase
    endfunction

    // ALU model: add/mul pipelined by L edges, output select combinational on alu_ctrl.
    logic [15:0] pa [L];
    logic [15:0] pb [L];
    always @(posedge clock) begin
        pa[0] <= alu_a;
        pb[0] <= alu_b;
        for (int k = 1; k < L; k++) begin
            pa[k] <= pa[k-1];
            pb[k] <= pb[k-1];
        end
    end

    function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] ca, input logic [15:0] cb);
        case (c)
            4'b0001: return r2bf(bf2r(a) + bf2r(b));
            4'b0010: return r2bf(bf2r(a) * bf2r(b));
            4'b0011: return ca + cb;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_y = alu_fn(alu_ctrl, pa[L-1], pb[L-1], alu_a, alu_b);

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [15:0] data;
        logic        err;
        int          acc;
    } ent_t;

    ent_t        sb_q[$];
    int          cyc = 0;
    logic [N-1:0] acc_vec = '0;
    int          lg_m = N - 1;
    int          last_acc = N - 1;
    int          resp_cnt = 0;
    int          max_inf = 0;
    logic [15:0] last_data [N];
    logic        last_err  [N];
    logic [N-1:0] last_rv = '0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        ent_t         e;
        logic [N-1:0] oh;
        logic [16:0]  r;
        logic [3:0]   exp_ctrl;
        if (!reset_n) begin
            sb_q.delete();
            lg_m    = N - 1;
            acc_vec = '0;
        end else begin
            if (resp_valid != '0) begin
                resp_cnt++;
                last_rv = resp_valid;
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("resp_valid", 32'(resp_valid), 32'(oh));
                    chk("resp_data", 32'(resp_data), 32'(e.data));
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_latency", cyc, e.acc + L + 1);
                    last_data[e.id] = resp_data;
                    last_err[e.id]  = resp_err;
                end
            end
            chk("inflight", 32'(inflight), sb_q.size());
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            exp_ctrl = 4'b0000;
            foreach (sb_q[k])
                if (sb_q[k].acc + L == cyc && (sb_q[k].op == 4'b0001 || sb_q[k].op == 4'b0010))
                    exp_ctrl = sb_q[k].op;
            chk("alu_ctrl", 32'(alu_ctrl), 32'(exp_ctrl));
            oh = '0;
            if (issue_en) begin
                for (int k = 1; k <= N; k++) begin
                    if (oh == '0 && req_valid[(lg_m + k) % N]) oh[(lg_m + k) % N] = 1'b1;
                end
            end
            chk("req_ready", 32'(req_ready), 32'(oh));
            acc_vec = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i]) begin
                    r = exp_of(req_op[i*4 +: 4], req_a[i*16 +: 16], req_b[i*16 +: 16]);
                    e.id = i; e.op = req_op[i*4 +: 4]; e.data = r[15:0]; e.err = r[16]; e.acc = cyc + 1;
                    sb_q.push_back(e);
                    lg_m = i;
                    last_acc = i;
                end
            end
        end
    end

    function automatic logic [15:0] rand_bf();
        logic [7:0] ex;
        ex = 8'($urandom_range(120, 134));
        return {1'($urandom), ex, 7'($urandom)};
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op[i*4 +: 4]   = op;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
        req_valid[i]       = 1'b1;
    endtask

    task automatic rand_req(input int i);
        int          p;
        logic [3:0]  op;
        p = $urandom_range(0, 9);
        if (p < 4)       op = 4'b0001;
        else if (p < 8)  op = 4'b0010;
        else if (p == 8) op = 4'b0011;
        else             op = 4'($urandom_range(4, 15));
        set_req(i, op, rand_bf(), rand_bf());
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) cycle();
        cycle();
        cycle();
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic single(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int base;
        cycle();
        base = resp_cnt;
        req_valid = '0;
        set_req(i, op, a, b);
        cycle();
        chk("single_accept", 32'(acc_vec[i]), 32'h1);
        req_valid[i] = 1'b0;
        for (int k = 0; k < 20 && resp_cnt == base; k++) cycle();
        chk("single_resp_count", resp_cnt, base + 1);
    endtask

    task automatic start_two();
        cycle();
        issue_en = 1'b1;
        for (int i = 0; i < N; i++) rand_req(i);
        cycle();
        for (int i = 0; i < N; i++) if (acc_vec[i]) rand_req(i);
        cycle();
        for (int i = 0; i < N; i++) if (acc_vec[i]) rand_req(i);
    endtask

    initial begin
        int           base;
        logic [N-1:0] oh;
        req_valid = '1;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_alu_b", 32'(alu_b), 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        req_valid = '0;
        #19 reset_n = 1'b1;

        single(0, 4'b0001, 16'h3F80, 16'h4000);
        chk("add_data", 32'(last_data[0]), 32'h4040);
        chk("add_err", 32'(last_err[0]), 32'h0);
        chk("add_rv", 32'(last_rv), 32'h1);
        single(2, 4'b0010, 16'h4000, 16'h4040);
        chk("mul_data", 32'(last_data[2]), 32'h40C0);
        chk("mul_rv", 32'(last_rv), 32'h4);
        drain();

        // all four requesters with fixed distinct ops, two full rounds
        cycle();
        set_req(0, 4'b0001, 16'h3F80, 16'h4000);
        set_req(1, 4'b0010, 16'h3F80, 16'h4040);
        set_req(2, 4'b0010, 16'h4000, 16'h4040);
        set_req(3, 4'b0001, 16'h4000, 16'h4000);
        repeat (8) cycle();
        req_valid = '0;
        drain();
        chk("rr_req0", 32'(last_data[0]), 32'h4040);
        chk("rr_req1", 32'(last_data[1]), 32'h4040);
        chk("rr_req2", 32'(last_data[2]), 32'h40C0);
        chk("rr_req3", 32'(last_data[3]), 32'h4080);
        chk("inflight_max", max_inf, L + 1);

        // unsupported op between supported neighbours
        cycle();
        set_req(0, 4'b0001, 16'h3F80, 16'h4000);
        set_req(1, 4'b0011, 16'h3F80, 16'h3F80);
        set_req(2, 4'b0010, 16'h4000, 16'h4040);
        for (int n = 0; n < 4; n++) begin
            cycle();
            for (int i = 0; i < N; i++) if (acc_vec[i]) req_valid[i] = 1'b0;
        end
        req_valid = '0;
        drain();
        chk("unsup_err", 32'(last_err[1]), 32'h1);
        chk("unsup_data", 32'(last_data[1]), 32'h0);
        chk("unsup_nb0", 32'(last_data[0]), 32'h4040);
        chk("unsup_nb2", 32'(last_data[2]), 32'h40C0);

        // continuous random load on all requesters
        for (int i = 0; i < N; i++) rand_req(i);
        for (int n = 0; n < 40; n++) begin
            cycle();
            for (int i = 0; i < N; i++) if (acc_vec[i]) rand_req(i);
        end
        req_valid = '0;
        drain();

        // issue_en drop with two ops in flight
        start_two();
        issue_en = 1'b0;
        base = resp_cnt;
        #1;
        chk("ien_ready_off", 32'(req_ready), 32'h0);
        chk("ien_inflight2", 32'(inflight), 32'h2);
        repeat (2 * L + 4) cycle();
        chk("ien_resp_count", resp_cnt, base + 2);
        chk("ien_inflight0", 32'(inflight), 32'h0);
        issue_en = 1'b1;
        oh = '0;
        oh[(last_acc + 1) % N] = 1'b1;
        #1;
        chk("ien_resume", 32'(req_ready), 32'(oh));
        cycle();
        req_valid = '0;
        drain();

        // reset with two ops in flight
        start_two();
        #1 reset_n = 1'b0;
        sb_q.delete();
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'h0);
        chk("mrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("mrst_resp_data", 32'(resp_data), 32'h0);
        chk("mrst_resp_err", 32'(resp_err), 32'h0);
        chk("mrst_alu_a", 32'(alu_a), 32'h0);
        chk("mrst_alu_b", 32'(alu_b), 32'h0);
        chk("mrst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("mrst_inflight", 32'(inflight), 32'h0);
        issue_en = 1'b0;
        repeat (3) cycle();
        #1 reset_n = 1'b1;
        base = resp_cnt;
        repeat (5) cycle();
        chk("mrst_no_resp", resp_cnt, base);
        issue_en = 1'b1;
        #1;
        chk("mrst_first_grant", 32'(req_ready), 32'h1);
        cycle();
        req_valid = '0;
        drain();

        // randomized traffic with issue_en toggling and request drops
        for (int n = 0; n < 300; n++) begin
            cycle();
            issue_en = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < N; i++) begin
                if (acc_vec[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 3) != 0) rand_req(i);
                    else req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        issue_en = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
